// File: rtl/button_event_queue_if.sv
// Event stream between the button event queue (master) and its consumer (slave).
// Handshake: a word transfers on any clock edge where o_evt_valid && i_evt_ready; data holds while valid && !ready.
interface button_event_queue_if;
    logic        o_evt_valid;
    logic [19:0] o_evt_data;
    logic        i_evt_ready;

    modport master (output o_evt_valid, output o_evt_data, input i_evt_ready);
    modport slave  (input o_evt_valid, input o_evt_data, output i_evt_ready);
endinterface

// File: rtl/button_event_queue.sv
// Debounces an 8-bit button vector on a slow sample tick and queues timestamped
// press/release events in a first-word-fall-through FIFO.
module button_event_queue #(
    parameter int CLK_RATE_HZ      = 50_000_000,
    parameter int SAMPLE_US        = 1000,
    parameter int DEBOUNCE_SAMPLES = 8,
    parameter int FIFO_DEPTH       = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic [7:0]                    i_button,
    output logic [7:0]                    o_button_stable,
    button_event_queue_if.master          evt,
    output logic [$clog2(FIFO_DEPTH):0]   o_evt_count,
    output logic                          o_overflow,
    input  logic                          i_clear_overflow
);

    localparam int SAMPLE_DIV = CLK_RATE_HZ / 1_000_000 * SAMPLE_US;
    localparam int PW = $clog2(SAMPLE_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]      btn_q;
    logic [PW-1:0]   presc;
    logic [15:0]     ts;
    logic [3:0]      cnt [8];
    logic [3:0]      cnt_n [8];
    logic [7:0]      stable;
    logic [7:0]      pending;
    logic [15:0]     pts [8];
    logic [19:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            valid_q;
    logic            overflow;

    logic            tick;
    logic [7:0]      accept;
    logic [7:0]      clr_mask;
    logic [2:0]      sel;
    logic            any_pending;
    logic            full;
    logic            push;
    logic            pop;
    logic            lost;
    logic [3:0]      cnt_inc;

    assign tick = (presc == PW'(SAMPLE_DIV - 1));
    assign full = (count == CW'(FIFO_DEPTH));
    assign pop  = valid_q && evt.i_evt_ready;

    always_comb begin
        accept  = '0;
        cnt_inc = '0;
        for (int i = 0; i < 8; i++) begin
            cnt_n[i] = cnt[i];
            cnt_inc  = cnt[i] + 4'd1;
            if (tick) begin
                if (btn_q[i] == stable[i]) begin
                    cnt_n[i] = '0;
                end else if (cnt_inc == 4'(DEBOUNCE_SAMPLES)) begin
                    cnt_n[i]  = '0;
                    accept[i] = 1'b1;
                end else begin
                    cnt_n[i] = cnt_inc;
                end
            end
        end
    end

    // Descending scan leaves the lowest pending index selected.
    always_comb begin
        sel         = '0;
        any_pending = |pending;
        for (int i = 7; i >= 0; i--) begin
            if (pending[i]) sel = 3'(i);
        end
        push     = any_pending && (!full || pop);
        clr_mask = push ? (8'b1 << sel) : 8'b0;
        lost     = |(accept & pending & ~clr_mask);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            btn_q    <= '0;
            presc    <= '0;
            ts       <= '0;
            stable   <= '0;
            pending  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            valid_q  <= 1'b0;
            overflow <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
                pts[i] <= '0;
            end
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                mem[j] <= '0;
            end
        end else begin
            btn_q <= i_button;
            if (tick) begin
                presc <= '0;
                ts    <= ts + 16'd1;
            end else begin
                presc <= presc + PW'(1);
            end

            for (int i = 0; i < 8; i++) begin
                cnt[i] <= cnt_n[i];
                if (accept[i]) begin
                    stable[i] <= btn_q[i];
                    pts[i]    <= ts;
                end
            end
            pending <= (pending & ~clr_mask) | accept;

            if (push) begin
                mem[wr_ptr] <= {stable[sel], sel, pts[sel]};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            // Pops retire immediately; a fresh write becomes visible one cycle later.
            valid_q <= ((count - CW'(pop)) != '0);

            if (lost) begin
                overflow <= 1'b1;
            end else if (i_clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    assign o_button_stable = stable;
    assign o_evt_count     = count;
    assign o_overflow      = overflow;
    assign evt.o_evt_valid = valid_q;
    assign evt.o_evt_data  = mem[rd_ptr];

endmodule

// File: tb/tb_button_event_queue.sv
// Directed bench for button_event_queue: SAMPLE_DIV=10, DEBOUNCE_SAMPLES=3, FIFO_DEPTH=4.
// Tick edges fall on cycles 10,20,30...; the timestamp captured at edge 10k is k-1.
module tb_button_event_queue;

    logic       clk;
    logic       rst_n;
    logic [7:0] button;
    logic [7:0] button_stable;
    logic [2:0] evt_count;
    logic       overflow;
    logic       clear_overflow;
    int         cyc;
    int         checks;
    int         failures;

    button_event_queue_if evt_bus ();

    button_event_queue #(
        .CLK_RATE_HZ      (1_000_000),
        .SAMPLE_US        (10),
        .DEBOUNCE_SAMPLES (3),
        .FIFO_DEPTH       (4)
    ) dut (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .i_button         (button),
        .o_button_stable  (button_stable),
        .evt              (evt_bus.master),
        .o_evt_count      (evt_count),
        .o_overflow       (overflow),
        .i_clear_overflow (clear_overflow)
    );

    // Clock / reset-relative cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns #1 after the posedge that brings the cycle count to e.
    task automatic wait_edge(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_stable"}, 32'(button_stable), 32'h0);
        check({tag, "_valid"}, 32'(evt_bus.o_evt_valid), 32'h0);
        check({tag, "_data"}, 32'(evt_bus.o_evt_data), 32'h0);
        check({tag, "_count"}, 32'(evt_count), 32'h0);
        check({tag, "_ovf"}, 32'(overflow), 32'h0);
    endtask

    logic [19:0] drain_exp [7];
    logic        bounce [6];

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        button   = 8'h04;
        clear_overflow      = 1'b0;
        evt_bus.i_evt_ready = 1'b0;
        #25;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: clean press of bit 2 held through reset
        wait_edge(29);
        check("press_pre_stable", 32'(button_stable), 32'h00);
        wait_edge(30);
        check("press_stable", 32'(button_stable), 32'h04);
        check("press_valid_e30", 32'(evt_bus.o_evt_valid), 32'h0);
        wait_edge(31);
        check("press_count_e31", 32'(evt_count), 32'h1);
        check("press_valid_e31", 32'(evt_bus.o_evt_valid), 32'h0);
        wait_edge(32);
        check("press_valid_e32", 32'(evt_bus.o_evt_valid), 32'h1);
        check("press_data", 32'(evt_bus.o_evt_data), 32'hA0002);
        evt_bus.i_evt_ready = 1'b1;
        wait_edge(33);
        check("press_pop_count", 32'(evt_count), 32'h0);
        check("press_pop_valid", 32'(evt_bus.o_evt_valid), 32'h0);
        evt_bus.i_evt_ready = 1'b0;

        // 2: bit 0 bounces 1,1,0,1,1,1 on ticks 40..90
        bounce = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            wait_edge(35 + 10 * i);
            button = 8'h04 | 8'(bounce[i]);
        end
        wait_edge(89);
        check("bounce_pre_stable", 32'(button_stable), 32'h04);
        check("bounce_no_glitch_evt", 32'(evt_count), 32'h0);
        wait_edge(90);
        check("bounce_stable", 32'(button_stable), 32'h05);
        wait_edge(92);
        check("bounce_valid", 32'(evt_bus.o_evt_valid), 32'h1);
        check("bounce_data", 32'(evt_bus.o_evt_data), 32'h80008);
        evt_bus.i_evt_ready = 1'b1;
        wait_edge(93);
        check("bounce_pop_count", 32'(evt_count), 32'h0);
        evt_bus.i_evt_ready = 1'b0;

        // 3a: release bits 0 and 2 together, accepted at edge 120
        wait_edge(95);
        button = 8'h00;
        wait_edge(122);
        check("rel_count", 32'(evt_count), 32'h2);
        check("rel_valid", 32'(evt_bus.o_evt_valid), 32'h1);
        check("rel_data0", 32'(evt_bus.o_evt_data), 32'h0000B);
        evt_bus.i_evt_ready = 1'b1;
        wait_edge(123);
        check("rel_data2", 32'(evt_bus.o_evt_data), 32'h2000B);
        check("rel_valid2", 32'(evt_bus.o_evt_valid), 32'h1);
        wait_edge(124);
        check("rel_empty", 32'(evt_count), 32'h0);
        evt_bus.i_evt_ready = 1'b0;

        // 3b: 0x00 -> 0x81 in one cycle, accepted at edge 150
        wait_edge(125);
        button = 8'h81;
        wait_edge(150);
        check("sim_stable", 32'(button_stable), 32'h81);
        evt_bus.i_evt_ready = 1'b1;
        wait_edge(151);
        check("sim_count_e151", 32'(evt_count), 32'h1);
        check("sim_valid_e151", 32'(evt_bus.o_evt_valid), 32'h0);
        wait_edge(152);
        check("sim_data_idx0", 32'(evt_bus.o_evt_data), 32'h8000E);
        check("sim_count_e152", 32'(evt_count), 32'h2);
        wait_edge(153);
        check("sim_valid_idx7", 32'(evt_bus.o_evt_valid), 32'h1);
        check("sim_data_idx7", 32'(evt_bus.o_evt_data), 32'hF000E);
        wait_edge(154);
        check("sim_empty", 32'(evt_count), 32'h0);
        check("sim_valid_done", 32'(evt_bus.o_evt_valid), 32'h0);

        // release 0x81 and drain it while ready stays high
        wait_edge(155);
        button = 8'h00;
        wait_edge(183);
        check("rel81_data7", 32'(evt_bus.o_evt_data), 32'h70011);
        wait_edge(185);
        check("rel81_empty", 32'(evt_count), 32'h0);
        evt_bus.i_evt_ready = 1'b0;

        // 4: press bits 0-2 (edge 210) then release (edge 240) with no consumer
        button = 8'h07;
        wait_edge(213);
        check("full_count3", 32'(evt_count), 32'h3);
        wait_edge(215);
        button = 8'h00;
        wait_edge(245);
        check("full_count_sat", 32'(evt_count), 32'h4);
        check("full_ovf_clear", 32'(overflow), 32'h0);
        check("full_head", 32'(evt_bus.o_evt_data), 32'h80014);

        // 5: bit 3 press accepted at 270, release at 300 while still pending
        button = 8'h08;
        wait_edge(275);
        button = 8'h00;
        wait_edge(299);
        check("loss_pre_ovf", 32'(overflow), 32'h0);
        wait_edge(300);
        check("loss_ovf_set", 32'(overflow), 32'h1);
        check("loss_stable", 32'(button_stable), 32'h00);
        wait_edge(305);
        check("loss_ovf_sticky", 32'(overflow), 32'h1);
        clear_overflow = 1'b1;
        wait_edge(306);
        clear_overflow = 1'b0;
        check("loss_ovf_cleared", 32'(overflow), 32'h0);

        drain_exp = '{20'h80014, 20'h90014, 20'hA0014, 20'h00017,
                      20'h10017, 20'h20017, 20'h3001D};
        for (int i = 0; i < 7; i++) begin
            wait_edge(306 + i);
            check($sformatf("drain_valid_%0d", i), 32'(evt_bus.o_evt_valid), 32'h1);
            check($sformatf("drain_data_%0d", i), 32'(evt_bus.o_evt_data), 32'(drain_exp[i]));
            if (i == 0) evt_bus.i_evt_ready = 1'b1;
        end
        wait_edge(313);
        check("drain_empty", 32'(evt_count), 32'h0);
        check("drain_valid_done", 32'(evt_bus.o_evt_valid), 32'h0);
        evt_bus.i_evt_ready = 1'b0;

        // 6: reset with three events queued while buttons stay held
        wait_edge(315);
        button = 8'h07;
        wait_edge(345);
        check("rst_pre_count", 32'(evt_count), 32'h3);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        wait_edge(29);
        check("rst_post_stable", 32'(button_stable), 32'h00);
        check("rst_post_valid", 32'(evt_bus.o_evt_valid), 32'h0);
        wait_edge(30);
        check("rst_held_stable", 32'(button_stable), 32'h07);
        wait_edge(33);
        check("rst_held_count", 32'(evt_count), 32'h3);
        check("rst_held_data", 32'(evt_bus.o_evt_data), 32'h80002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
